id_stage_pipe: RTL and testbench

Parametrised decode stage with integrated ID/EX pipeline register for the MIPS pipeline. It decodes the logic, shift, move and NOP-class instruction subset and bypasses operands from EX and MEM (and, optionally, WB). It detects load-use hazards and inserts bubbles. Output is held in a registered valid/ready slot between fetch and execute.

---
 rtl/id_stage_pipe_if.sv | 35 +++
 rtl/id_stage_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: fetch-side handshake and ID/EX output bus of the decode stage.
// The slave modport is the decode stage's view; the master modport is the view
// of whatever drives fetch and consumes the ID/EX slot.
interface id_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [PC_W-1:0]   pc_i;
    logic [31:0]       inst_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [PC_W-1:0]   pc_o;
    logic [7:0]        aluop_o;
    logic [2:0]        alusel_o;
    logic [DATA_W-1:0] reg1_o;
    logic [DATA_W-1:0] reg2_o;
    logic [REG_AW-1:0] wd_o;
    logic              wreg_o;
    logic              inst_invalid_o;

    modport slave (
        input  in_valid_i, pc_i, inst_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, aluop_o, alusel_o,
               reg1_o, reg2_o, wd_o, wreg_o, inst_invalid_o
    );

    modport master (
        output in_valid_i, pc_i, inst_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, aluop_o, alusel_o,
               reg1_o, reg2_o, wd_o, wreg_o, inst_invalid_o
    );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage (logic/shift/move/nop subset) with operand
// bypass from EX and MEM, load-use stall detection and a registered ID/EX
// valid/ready slot.
// Optional feature: define ID_WB_FWD_EN to add a WB bypass at the lowest
// forwarding priority (ahead of the regfile). Without it the wb_* inputs are
// ignored and the regfile is expected to provide write-before-read.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    id_stage_pipe_if.slave    bus,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    output logic [REG_AW-1:0] reg1_addr_o,
    output logic [REG_AW-1:0] reg2_addr_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_load_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              wb_wreg_i,
    input  logic [REG_AW-1:0] wb_wd_i,
    input  logic [DATA_W-1:0] wb_wdata_i,
    input  logic              flush_i,
    output logic              stallreq_o
);
    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_PREF    = 6'b110011;

    // SPECIAL function codes
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_MOVZ = 6'b001010;
    localparam logic [5:0] F_MOVN = 6'b001011;
    localparam logic [5:0] F_SYNC = 6'b001111;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;

    // ALU operation codes seen by EX
    localparam logic [7:0] ALU_NOP  = 8'b0000_0000;
    localparam logic [7:0] ALU_OR   = 8'b0010_0101;
    localparam logic [7:0] ALU_AND  = 8'b0010_0100;
    localparam logic [7:0] ALU_XOR  = 8'b0010_0110;
    localparam logic [7:0] ALU_NOR  = 8'b0010_0111;
    localparam logic [7:0] ALU_SLL  = 8'b0111_1100;
    localparam logic [7:0] ALU_SRL  = 8'b0000_0010;
    localparam logic [7:0] ALU_SRA  = 8'b0000_0011;
    localparam logic [7:0] ALU_SLLV = 8'b0000_0100;
    localparam logic [7:0] ALU_SRLV = 8'b0000_0110;
    localparam logic [7:0] ALU_SRAV = 8'b0000_0111;
    localparam logic [7:0] ALU_MOVZ = 8'b0000_1010;
    localparam logic [7:0] ALU_MOVN = 8'b0000_1011;
    localparam logic [7:0] ALU_MFHI = 8'b0001_0000;
    localparam logic [7:0] ALU_MTHI = 8'b0001_0001;
    localparam logic [7:0] ALU_MFLO = 8'b0001_0010;
    localparam logic [7:0] ALU_MTLO = 8'b0001_0011;

    // Result selectors
    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

    // Instruction fields
    logic [5:0]  op_w;
    logic [5:0]  funct_w;
    logic [4:0]  rs_w;
    logic [4:0]  rt_w;
    logic [4:0]  rd_w;
    logic [4:0]  sa_w;
    logic [15:0] imm16_w;

    assign op_w    = bus.inst_i[31:26];
    assign rs_w    = bus.inst_i[25:21];
    assign rt_w    = bus.inst_i[20:16];
    assign rd_w    = bus.inst_i[15:11];
    assign sa_w    = bus.inst_i[10:6];
    assign funct_w = bus.inst_i[5:0];
    assign imm16_w = bus.inst_i[15:0];

    // Decode results
    logic [7:0]        aluop_d;
    logic [2:0]        alusel_d;
    logic              r1_en_d;
    logic              r2_en_d;
    logic              wreg_dec_d;
    logic [REG_AW-1:0] wd_d;
    logic [DATA_W-1:0] imm_d;
    logic              invalid_d;
    logic              is_movz_d;
    logic              is_movn_d;

    // Forwarded operands and final write enable
    logic [DATA_W-1:0] reg1_d;
    logic [DATA_W-1:0] reg2_d;
    logic              wreg_d;

    // ID/EX slot
    logic              valid_q;
    logic [PC_W-1:0]   pc_q;
    logic [7:0]        aluop_q;
    logic [2:0]        alusel_q;
    logic [DATA_W-1:0] reg1_q;
    logic [DATA_W-1:0] reg2_q;
    logic [REG_AW-1:0] wd_q;
    logic              wreg_q;
    logic              invalid_q;

    logic accept_w;

    // Youngest-first bypass: $0 is hard zero, then EX, MEM, optional WB, regfile.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic              en,
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic [DATA_W-1:0] imm
    );
        logic [DATA_W-1:0] res;
        if (!en) begin
            res = imm;
        end else if (addr == '0) begin
            res = '0;
        end else if (ex_wreg_i && ex_wd_i == addr) begin
            res = ex_wdata_i;
        end else if (mem_wreg_i && mem_wd_i == addr) begin
            res = mem_wdata_i;
`ifdef ID_WB_FWD_EN
        end else if (wb_wreg_i && wb_wd_i == addr) begin
            res = wb_wdata_i;
`endif
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

`ifndef ID_WB_FWD_EN
    logic wb_unused;
    assign wb_unused = ^{wb_wreg_i, wb_wd_i, wb_wdata_i};
`endif

    // Instruction decode: ALU control, read enables, destination and immediate.
    always_comb begin
        aluop_d    = ALU_NOP;
        alusel_d   = SEL_NOP;
        r1_en_d    = 1'b0;
        r2_en_d    = 1'b0;
        wreg_dec_d = 1'b0;
        wd_d       = REG_AW'(rd_w);
        imm_d      = '0;
        invalid_d  = 1'b1;
        is_movz_d  = 1'b0;
        is_movn_d  = 1'b0;
        case (op_w)
            OP_SPECIAL: begin
                case (funct_w)
                    F_OR, F_AND, F_XOR, F_NOR: begin
                        alusel_d   = SEL_LOGIC;
                        r1_en_d    = 1'b1;
                        r2_en_d    = 1'b1;
                        wreg_dec_d = 1'b1;
                        invalid_d  = 1'b0;
                        case (funct_w)
                            F_OR:    aluop_d = ALU_OR;
                            F_AND:   aluop_d = ALU_AND;
                            F_XOR:   aluop_d = ALU_XOR;
                            default: aluop_d = ALU_NOR;
                        endcase
                    end
                    F_SLLV, F_SRLV, F_SRAV: begin
                        alusel_d   = SEL_SHIFT;
                        r1_en_d    = 1'b1;
                        r2_en_d    = 1'b1;
                        wreg_dec_d = 1'b1;
                        invalid_d  = 1'b0;
                        case (funct_w)
                            F_SLLV:  aluop_d = ALU_SLLV;
                            F_SRLV:  aluop_d = ALU_SRLV;
                            default: aluop_d = ALU_SRAV;
                        endcase
                    end
                    F_SLL, F_SRL, F_SRA: begin
                        // Only valid with rs field zero; sa goes into operand 1
                        if (rs_w == 5'd0) begin
                            alusel_d   = SEL_SHIFT;
                            r2_en_d    = 1'b1;
                            wreg_dec_d = 1'b1;
                            imm_d      = DATA_W'(sa_w);
                            invalid_d  = 1'b0;
                            case (funct_w)
                                F_SLL:   aluop_d = ALU_SLL;
                                F_SRL:   aluop_d = ALU_SRL;
                                default: aluop_d = ALU_SRA;
                            endcase
                        end
                    end
                    F_MFHI, F_MFLO: begin
                        alusel_d   = SEL_MOVE;
                        aluop_d    = (funct_w == F_MFHI) ? ALU_MFHI : ALU_MFLO;
                        wreg_dec_d = 1'b1;
                        invalid_d  = 1'b0;
                    end
                    F_MTHI, F_MTLO: begin
                        aluop_d   = (funct_w == F_MTHI) ? ALU_MTHI : ALU_MTLO;
                        r1_en_d   = 1'b1;
                        invalid_d = 1'b0;
                    end
                    F_MOVZ, F_MOVN: begin
                        alusel_d  = SEL_MOVE;
                        aluop_d   = (funct_w == F_MOVZ) ? ALU_MOVZ : ALU_MOVN;
                        r1_en_d   = 1'b1;
                        r2_en_d   = 1'b1;
                        is_movz_d = (funct_w == F_MOVZ);
                        is_movn_d = (funct_w == F_MOVN);
                        invalid_d = 1'b0;
                    end
                    F_SYNC: begin
                        invalid_d = 1'b0;
                    end
                    default: begin
                        invalid_d = 1'b1;
                    end
                endcase
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                alusel_d   = SEL_LOGIC;
                r1_en_d    = 1'b1;
                wreg_dec_d = 1'b1;
                wd_d       = REG_AW'(rt_w);
                imm_d      = DATA_W'({16'h0000, imm16_w});
                invalid_d  = 1'b0;
                case (op_w)
                    OP_ORI:  aluop_d = ALU_OR;
                    OP_ANDI: aluop_d = ALU_AND;
                    default: aluop_d = ALU_XOR;
                endcase
            end
            OP_LUI: begin
                // Executed as rs | (imm << 16); rs is $0 in a well-formed lui
                alusel_d   = SEL_LOGIC;
                aluop_d    = ALU_OR;
                r1_en_d    = 1'b1;
                wreg_dec_d = 1'b1;
                wd_d       = REG_AW'(rt_w);
                imm_d      = DATA_W'({imm16_w, 16'h0000});
                invalid_d  = 1'b0;
            end
            OP_PREF: begin
                invalid_d = 1'b0;
            end
            default: begin
                invalid_d = 1'b1;
            end
        endcase
    end

    assign reg1_read_o = r1_en_d;
    assign reg2_read_o = r2_en_d;
    assign reg1_addr_o = REG_AW'(rs_w);
    assign reg2_addr_o = REG_AW'(rt_w);

    // Operand selection and conditional-move write enable on the bypassed reg2.
    always_comb begin
        reg1_d = pick_operand(r1_en_d, reg1_addr_o, reg1_data_i, imm_d);
        reg2_d = pick_operand(r2_en_d, reg2_addr_o, reg2_data_i, imm_d);
        wreg_d = wreg_dec_d;
        if (is_movz_d) begin
            wreg_d = (reg2_d == '0);
        end else if (is_movn_d) begin
            wreg_d = (reg2_d != '0);
        end
    end

    // Load-use hazard: EX holds a load whose data a read port needs now.
    assign stallreq_o = bus.in_valid_i && ex_wreg_i && ex_load_i && (ex_wd_i != '0) &&
                        ((r1_en_d && ex_wd_i == reg1_addr_o) ||
                         (r2_en_d && ex_wd_i == reg2_addr_o));

    assign bus.in_ready_o = flush_i || (!stallreq_o && (!valid_q || bus.out_ready_i));
    assign accept_w       = bus.in_valid_i && bus.in_ready_o && !flush_i;

    // ID/EX slot: flush beats accept; a drain without accept leaves a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            aluop_q   <= '0;
            alusel_q  <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            wd_q      <= '0;
            wreg_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (accept_w) begin
            valid_q   <= 1'b1;
            pc_q      <= bus.pc_i;
            aluop_q   <= aluop_d;
            alusel_q  <= alusel_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            wd_q      <= wd_d;
            wreg_q    <= wreg_d && !invalid_d;
            invalid_q <= invalid_d;
        end else if (bus.out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid_o    = valid_q;
    assign bus.pc_o           = pc_q;
    assign bus.aluop_o        = aluop_q;
    assign bus.alusel_o       = alusel_q;
    assign bus.reg1_o         = reg1_q;
    assign bus.reg2_o         = reg2_q;
    assign bus.wd_o           = wd_q;
    assign bus.wreg_o         = wreg_q;
    assign bus.inst_invalid_o = invalid_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vectors for id_stage_pipe with a scoreboard queue;
// a monitor pops and compares whenever the ID/EX slot transfers.
module tb_id_stage_pipe;
    logic        clk;
    logic        rst;
    logic        reg1_read, reg2_read;
    logic [4:0]  reg1_addr, reg2_addr;
    logic [31:0] reg1_data, reg2_data;
    logic        ex_wreg, ex_load, mem_wreg, wb_wreg, flush, stallreq;
    logic [4:0]  ex_wd, mem_wd, wb_wd;
    logic [31:0] ex_wdata, mem_wdata, wb_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage_pipe_if #(.DATA_W(32), .PC_W(32), .REG_AW(5)) ifc ();

    id_stage_pipe #(.DATA_W(32), .PC_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .bus(ifc),
        .reg1_read_o(reg1_read), .reg2_read_o(reg2_read),
        .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
        .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_load_i(ex_load),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .wb_wreg_i(wb_wreg), .wb_wd_i(wb_wd), .wb_wdata_i(wb_wdata),
        .flush_i(flush), .stallreq_o(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic        inv;
    } exp_t;

    exp_t sb[$];

    task automatic push(input string nm, input logic [31:0] pc, input logic [7:0] aluop,
                        input logic [2:0] alusel, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] wd, input logic wreg, input logic inv);
        exp_t e;
        e.name = nm; e.pc = pc; e.aluop = aluop; e.alusel = alusel;
        e.r1 = r1; e.r2 = r2; e.wd = wd; e.wreg = wreg; e.inv = inv;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every transfer out of the slot is matched against the queue head.
    always @(negedge clk) begin
        if (!rst && ifc.out_valid_o && ifc.out_ready_i) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got pc=0x%08h, none expected", ifc.pc_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ifc.pc_o !== e.pc || ifc.aluop_o !== e.aluop || ifc.alusel_o !== e.alusel ||
                    ifc.reg1_o !== e.r1 || ifc.reg2_o !== e.r2 || ifc.wreg_o !== e.wreg ||
                    ifc.inst_invalid_o !== e.inv || (e.wreg && ifc.wd_o !== e.wd)) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%h op=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b inv=%b expected pc=%h op=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b inv=%b",
                             e.name, ifc.pc_o, ifc.aluop_o, ifc.alusel_o, ifc.reg1_o, ifc.reg2_o,
                             ifc.wd_o, ifc.wreg_o, ifc.inst_invalid_o,
                             e.pc, e.aluop, e.alusel, e.r1, e.r2, e.wd, e.wreg, e.inv);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ifc.in_valid_i = 1'b0; ifc.inst_i = '0; ifc.pc_i = '0;
        reg1_data = '0; reg2_data = '0;
        ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0; ex_load = 1'b0;
        mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;
        wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
        flush = 1'b0;
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        ifc.in_valid_i = 1'b1;
        ifc.inst_i     = inst;
        ifc.pc_i       = pc;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        ifc.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, ifc.out_valid_o}, 32'd0);
        chk("rst_wreg", {31'b0, ifc.wreg_o}, 32'd0);
        chk("rst_inst_invalid", {31'b0, ifc.inst_invalid_o}, 32'd0);
        chk("rst_reg1", ifc.reg1_o, 32'd0);
        chk("rst_pc", ifc.pc_o, 32'd0);
        chk("rst_aluop", {24'b0, ifc.aluop_o}, 32'd0);
        rst = 1'b0;
        tick();

        // or $3,$1,$2: EX beats MEM for $1, $2 from regfile
        clr();
        present(32'h0022_1825, 32'h100);
        ex_wreg = 1'b1; ex_wd = 5'd1; ex_wdata = 32'h11;
        mem_wreg = 1'b1; mem_wd = 5'd1; mem_wdata = 32'h22;
        reg1_data = 32'h99; reg2_data = 32'h0F;
        push("or_fwd", 32'h100, 8'h25, 3'd1, 32'h11, 32'h0F, 5'd3, 1'b1, 1'b0);
        tick();

        // andi $5,$4,0xFF behind a load to $4: stall, bubble, then MEM bypass
        clr();
        present(32'h3085_00FF, 32'h104);
        ex_wreg = 1'b1; ex_load = 1'b1; ex_wd = 5'd4; ex_wdata = 32'hBAD;
        @(negedge clk);
        chk("stall_req", {31'b0, stallreq}, 32'd1);
        chk("stall_in_ready", {31'b0, ifc.in_ready_o}, 32'd0);
        tick();
        clr();
        present(32'h3085_00FF, 32'h104);
        mem_wreg = 1'b1; mem_wd = 5'd4; mem_wdata = 32'h1234;
        reg1_data = 32'h5555;
        push("andi_after_stall", 32'h104, 8'h24, 3'd1, 32'h1234, 32'hFF, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("stall_bubble", {31'b0, ifc.out_valid_o}, 32'd0);
        chk("no_stall_after", {31'b0, stallreq}, 32'd0);
        tick();

        // movz/movz/movn back to back, reg2 taken from EX
        clr();
        present(32'h00E8_300A, 32'h108);
        ex_wreg = 1'b1; ex_wd = 5'd8; ex_wdata = 32'd0;
        reg1_data = 32'h55; reg2_data = 32'h77;
        push("movz_zero", 32'h108, 8'h0A, 3'd3, 32'h55, 32'h0, 5'd6, 1'b1, 1'b0);
        tick();
        present(32'h00E8_300A, 32'h10C);
        ex_wdata = 32'd5;
        push("movz_nonzero", 32'h10C, 8'h0A, 3'd3, 32'h55, 32'h5, 5'd6, 1'b0, 1'b0);
        tick();
        present(32'h00E8_300B, 32'h110);
        push("movn_nonzero", 32'h110, 8'h0B, 3'd3, 32'h55, 32'h5, 5'd6, 1'b1, 1'b0);
        tick();

        // ori / xori zero-extended immediates
        clr();
        present(32'h342A_00F0, 32'h114);
        reg1_data = 32'h0F0F;
        push("ori", 32'h114, 8'h25, 3'd1, 32'h0F0F, 32'hF0, 5'd10, 1'b1, 1'b0);
        tick();
        present(32'h384B_1234, 32'h118);
        reg1_data = 32'hAAAA;
        push("xori", 32'h118, 8'h26, 3'd1, 32'hAAAA, 32'h1234, 5'd11, 1'b1, 1'b0);
        tick();

        // $0 reads are zero even with EX claiming a write to $0
        clr();
        present(32'h0000_0825, 32'h11C);
        ex_wreg = 1'b1; ex_wd = 5'd0; ex_wdata = 32'hFFFF_FFFF;
        reg1_data = 32'hDEAD; reg2_data = 32'hDEAD;
        push("or_r0", 32'h11C, 8'h25, 3'd1, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        tick();

        // Unrecognised opcode 0x3F
        clr();
        present(32'hFC22_1234, 32'h120);
        reg1_data = 32'h1; reg2_data = 32'h2;
        push("invalid_op", 32'h120, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();

        // sll $2,$3,7 with WB writing $3=1 and stale regfile $3=0
        clr();
        present(32'h0003_11C0, 32'h124);
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h1;
        reg2_data = 32'h0;
`ifdef ID_WB_FWD_EN
        push("sll_wb", 32'h124, 8'h7C, 3'd2, 32'h7, 32'h1, 5'd2, 1'b1, 1'b0);
`else
        push("sll_wb", 32'h124, 8'h7C, 3'd2, 32'h7, 32'h0, 5'd2, 1'b1, 1'b0);
`endif
        tick();

        // lui accepted, held under backpressure, then flushed
        clr();
        present(32'h3C09_ABCD, 32'h128);
        tick();
        ifc.out_ready_i = 1'b0;
        present(32'h384B_1234, 32'h12C);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, ifc.out_valid_o}, 32'd1);
            chk("hold_reg2", ifc.reg2_o, 32'hABCD_0000);
            chk("hold_pc", ifc.pc_o, 32'h128);
            chk("hold_in_ready", {31'b0, ifc.in_ready_o}, 32'd0);
            tick();
        end
        clr();
        flush = 1'b1;
        present(32'h3085_00FF, 32'h130);
        ex_wreg = 1'b1; ex_load = 1'b1; ex_wd = 5'd4;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, ifc.in_ready_o}, 32'd1);
        chk("flush_stallreq", {31'b0, stallreq}, 32'd1);
        tick();
        clr();
        @(negedge clk);
        chk("flush_cleared", {31'b0, ifc.out_valid_o}, 32'd0);
        tick();

        // Asynchronous reset between clock edges empties the slot at once
        clr();
        present(32'h342A_00F0, 32'h134);
        reg1_data = 32'h1;
        tick();
        clr();
        @(negedge clk);
        chk("pre_areset_valid", {31'b0, ifc.out_valid_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("areset_valid", {31'b0, ifc.out_valid_o}, 32'd0);
        chk("areset_reg2", ifc.reg2_o, 32'd0);
        chk("areset_pc", ifc.pc_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ifc.out_ready_i = 1'b1;
        repeat (2) tick();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
